// File: rtl/ccff_chain_monitor.sv
// Loopback integrity checker for the configuration chain: every returned tail bit is
// compared with the bit shifted in CHAIN_LEN progclk edges earlier. Optional macro: CCFF_FIRST_ERR_EN.
module ccff_chain_monitor #(
  parameter int CHAIN_LEN = 64,
  parameter int DEPTH     = 64,
  parameter int CNT_W     = 16,
  parameter int ERR_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic             stop_i,
  input  logic             progclk_i,
  input  logic             data_i,
  input  logic             ccff_tail_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_o
`ifdef CCFF_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0] first_err_o,
  output logic             first_err_vld_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    CHECK,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic             pc_q;
  logic             pc_rise;
  logic             active;
  logic             take;
  logic             mismatch;
  logic             stop_hit;
  logic             fill_done;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] bit_cnt_next;
  logic [ERR_W-1:0] err_cnt_next;
  logic             hist [DEPTH];

  // An arm in the same cycle as an edge wins, so the edge never reaches the history.
  assign pc_rise  = progclk_i & ~pc_q;
  assign active   = (state == FILL) || (state == CHECK);
  assign take     = active & pc_rise & ~arm_i;
  assign stop_hit = active & stop_i & ~arm_i;
  assign rd_ptr   = wr_ptr - PTR_W'(CHAIN_LEN);
  assign mismatch = take & (state == CHECK) & (ccff_tail_i != hist[rd_ptr]);

  assign bit_cnt_next = (take && (bit_cnt_o != '1)) ? bit_cnt_o + 1'b1 : bit_cnt_o;
  assign err_cnt_next = (mismatch && (err_cnt_o != '1)) ? err_cnt_o + 1'b1 : err_cnt_o;
  assign fill_done    = (bit_cnt_next >= CNT_W'(CHAIN_LEN));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // CHECK is entered on the same edge that brings the count to CHAIN_LEN.
  always_comb begin
    state_next = state;
    if (arm_i) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL: begin
          if (stop_i) begin
            state_next = DONE;
          end else if (fill_done) begin
            state_next = CHECK;
          end
        end
        CHECK: begin
          if (stop_i) begin
            state_next = DONE;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // The verdict uses the post-edge error count so a coincident edge is included.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      err_cnt_o <= '0;
      bit_cnt_o <= '0;
      wr_ptr    <= '0;
    end else begin
      pc_q   <= progclk_i;
      busy_o <= (state_next == FILL) || (state_next == CHECK);
      if (arm_i) begin
        done_o    <= 1'b0;
        pass_o    <= 1'b0;
        err_cnt_o <= '0;
        bit_cnt_o <= '0;
        wr_ptr    <= '0;
      end else begin
        err_cnt_o <= err_cnt_next;
        bit_cnt_o <= bit_cnt_next;
        if (take) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (stop_hit) begin
          done_o <= 1'b1;
          pass_o <= (err_cnt_next == '0) && (state == CHECK);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (take) begin
      hist[wr_ptr] <= data_i;
    end
  end

`ifdef CCFF_FIRST_ERR_EN
  // Only the earliest mismatch after arm is kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      first_err_o     <= '0;
      first_err_vld_o <= 1'b0;
    end else if (arm_i) begin
      first_err_o     <= '0;
      first_err_vld_o <= 1'b0;
    end else if (mismatch && !first_err_vld_o) begin
      first_err_o     <= bit_cnt_o;
      first_err_vld_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ccff_chain_monitor.sv
// Directed self-checking bench for ccff_chain_monitor; the chain is modelled as a
// record of sent bits so each tail bit is the one sent CHAIN_LEN edges earlier.
module tb_ccff_chain_monitor;

  localparam int CHAIN_LEN = 64;
  localparam int DEPTH     = 64;
  localparam int CNT_W     = 16;
  localparam int ERR_W     = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             arm_i = 1'b0;
  logic             stop_i = 1'b0;
  logic             progclk_i = 1'b0;
  logic             data_i = 1'b0;
  logic             ccff_tail_i = 1'b0;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic [CNT_W-1:0] bit_cnt_o;
`ifdef CCFF_FIRST_ERR_EN
  logic [CNT_W-1:0] first_err_o;
  logic             first_err_vld_o;
`endif

  int   checks = 0;
  int   failures = 0;
  int   n_edges = 0;
  logic sent [0:1023];

  ccff_chain_monitor #(
    .CHAIN_LEN(CHAIN_LEN),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W),
    .ERR_W    (ERR_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .arm_i          (arm_i),
    .stop_i         (stop_i),
    .progclk_i      (progclk_i),
    .data_i         (data_i),
    .ccff_tail_i    (ccff_tail_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .pass_o         (pass_o),
    .err_cnt_o      (err_cnt_o),
    .bit_cnt_o      (bit_cnt_o)
`ifdef CCFF_FIRST_ERR_EN
    ,
    .first_err_o    (first_err_o),
    .first_err_vld_o(first_err_vld_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_arm();
    @(negedge clk_i);
    arm_i = 1'b1;
    @(negedge clk_i);
    arm_i = 1'b0;
    n_edges = 0;
  endtask

  task automatic pulse_stop();
    @(negedge clk_i);
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
  endtask

  // One progclk pulse; the tail is the correct chain output unless flipped.
  task automatic apply_stimulus(input bit flip);
    logic d;
    logic t;
    d = 1'($urandom_range(0, 1));
    if (n_edges >= CHAIN_LEN) t = sent[n_edges-CHAIN_LEN];
    else t = 1'($urandom_range(0, 1));
    if (flip) t = ~t;
    sent[n_edges] = d;
    @(negedge clk_i);
    progclk_i   = 1'b1;
    data_i      = d;
    ccff_tail_i = t;
    @(negedge clk_i);
    progclk_i = 1'b0;
    n_edges++;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk_i);
    check_output("rst_busy", busy_o, 0);
    check_output("rst_done", done_o, 0);
    check_output("rst_pass", pass_o, 0);
    check_output("rst_err", err_cnt_o, 0);
    check_output("rst_bits", bit_cnt_o, 0);
    rst_i = 1'b0;

    // clean 200-bit run
    pulse_arm();
    check_output("a_busy_after_arm", busy_o, 1);
    check_output("a_bits_after_arm", bit_cnt_o, 0);
    for (int i = 0; i < 64; i++) apply_stimulus(1'b0);
    check_output("a_bits_64", bit_cnt_o, 64);
    for (int i = 64; i < 200; i++) apply_stimulus(1'b0);
    pulse_stop();
    check_output("a_done", done_o, 1);
    check_output("a_pass", pass_o, 1);
    check_output("a_err", err_cnt_o, 0);
    check_output("a_bits", bit_cnt_o, 200);
    check_output("a_busy_done", busy_o, 0);

    // edges after the verdict are ignored
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0);
    check_output("done_edges_bits", bit_cnt_o, 200);
    check_output("done_edges_done", done_o, 1);

    // two corrupted tail bits at edges 70 and 150
    pulse_arm();
    check_output("b_done_cleared", done_o, 0);
    for (int i = 0; i < 200; i++) apply_stimulus(i == 70 || i == 150);
    pulse_stop();
    check_output("b_done", done_o, 1);
    check_output("b_pass", pass_o, 0);
    check_output("b_err", err_cnt_o, 2);
    check_output("b_bits", bit_cnt_o, 200);
`ifdef CCFF_FIRST_ERR_EN
    check_output("b_first_err", first_err_o, 70);
    check_output("b_first_vld", first_err_vld_o, 1);
`endif

    // arm and stop together: arm wins
    @(negedge clk_i);
    arm_i  = 1'b1;
    stop_i = 1'b1;
    @(negedge clk_i);
    arm_i  = 1'b0;
    stop_i = 1'b0;
    n_edges = 0;
    check_output("c_arm_wins_done", done_o, 0);
    check_output("c_arm_wins_busy", busy_o, 1);
`ifdef CCFF_FIRST_ERR_EN
    check_output("c_first_vld_cleared", first_err_vld_o, 0);
`endif

    // stop during fill
    for (int i = 0; i < 40; i++) apply_stimulus(1'b0);
    pulse_stop();
    check_output("c_done", done_o, 1);
    check_output("c_pass", pass_o, 0);
    check_output("c_err", err_cnt_o, 0);
    check_output("c_bits", bit_cnt_o, 40);

    // every tail inverted: error count saturates
    pulse_arm();
    for (int i = 0; i < 600; i++) apply_stimulus(1'b1);
    pulse_stop();
    check_output("d_err_sat", err_cnt_o, 255);
    check_output("d_pass", pass_o, 0);
    check_output("d_bits", bit_cnt_o, 600);
    check_output("d_done", done_o, 1);

    // re-arm while checking
    pulse_arm();
    for (int i = 0; i < 64; i++) apply_stimulus(1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1);
    check_output("e_err_before", err_cnt_o, 3);
    check_output("e_busy_before", busy_o, 1);
    pulse_arm();
    check_output("e_err_rearm", err_cnt_o, 0);
    check_output("e_bits_rearm", bit_cnt_o, 0);
    check_output("e_done_rearm", done_o, 0);
    check_output("e_busy_rearm", busy_o, 1);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1);
    check_output("e_fill_no_compare", err_cnt_o, 0);
    check_output("e_fill_bits", bit_cnt_o, 10);

    // asynchronous reset mid-check
    pulse_arm();
    for (int i = 0; i < 64; i++) apply_stimulus(1'b0);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b1);
    check_output("f_err_before", err_cnt_o, 2);
    #2;
    rst_i = 1'b1;
    #1;
    check_output("f_rst_busy", busy_o, 0);
    check_output("f_rst_done", done_o, 0);
    check_output("f_rst_pass", pass_o, 0);
    check_output("f_rst_err", err_cnt_o, 0);
    check_output("f_rst_bits", bit_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
